// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl
//
// Command-driven sequencer for a WIDTH-bit Johnson (twisted-ring) counter.
// A command (step count, direction, optional seed load) is accepted over a
// valid/ready handshake in IDLE. The register is then shifted once per
// non-held cycle in RUN, and a one-cycle done pulse follows in DONE.
//
// Parameters
//   WIDTH  Johnson register width (>= 2); sequence length 2*WIDTH
//   CNT_W  step-count width
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (IDLE only)
//   cmd_steps  number of shifts to perform (0 allowed)
//   cmd_dir    0 = forward, 1 = reverse
//   cmd_load   load cmd_seed on acceptance
//   cmd_seed   load value
//   hold       freezes stepping while in RUN
//   dout       Johnson register
//   phase      one-hot phase decode of dout; all-zero when dout is illegal
//   busy       state != IDLE
//   done       one-cycle completion pulse
//   err        sticky illegal-seed flag
//
// Build option
//   JSEQ_ILLEGAL_RECOVERY_EN  when defined, an illegal seed is replaced by 0
//                             and err is raised until the next acceptance;
//                             otherwise the seed is loaded as-is and err = 0.

module johnson_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_W-1:0]     cmd_steps,
  input  logic                 cmd_dir,
  input  logic                 cmd_load,
  input  logic [WIDTH-1:0]     cmd_seed,
  input  logic                 hold,
  output logic [WIDTH-1:0]     dout,
  output logic [2*WIDTH-1:0]   phase,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned PW = $clog2(2 * WIDTH);
  localparam logic [2*WIDTH-1:0] PHASE0 = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   dout_q, dout_n;
  logic [CNT_W-1:0]   rem_q, rem_n;
  logic               dir_q, dir_n;

  logic [PW-1:0]      ones_cnt;
  logic [PW-1:0]      phase_idx;
  logic               dout_legal;

  // A legal Johnson code has at most one bit transition across the word.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    logic [PW-1:0] trans;
    trans = '0;
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      trans = trans + PW'(v[i] ^ v[i+1]);
    end
    return trans < PW'(2);
  endfunction

  function automatic logic [WIDTH-1:0] shift_fwd(input logic [WIDTH-1:0] v);
    return {~v[0], v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_rev(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ~v[WIDTH-1]};
  endfunction

  // Phase decode. With dout[0]=1 the index is WIDTH + zeros = 2*WIDTH - ones;
  // computed modulo 2^PW, which is exact since ones >= 1 in that case.
  always_comb begin
    ones_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + PW'(dout_q[i]);
    end
    phase_idx  = dout_q[0] ? (PW'(2 * WIDTH) - ones_cnt) : ones_cnt;
    dout_legal = is_legal(dout_q);
    phase      = dout_legal ? (PHASE0 << phase_idx) : '0;
  end

`ifdef JSEQ_ILLEGAL_RECOVERY_EN
  logic err_q, err_n;
`endif

  always_comb begin
    state_n = state;
    dout_n  = dout_q;
    rem_n   = rem_q;
    dir_n   = dir_q;
`ifdef JSEQ_ILLEGAL_RECOVERY_EN
    err_n   = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          rem_n = cmd_steps;
          dir_n = cmd_dir;
`ifdef JSEQ_ILLEGAL_RECOVERY_EN
          err_n = 1'b0;
          if (cmd_load) begin
            if (is_legal(cmd_seed)) begin
              dout_n = cmd_seed;
            end else begin
              dout_n = '0;
              err_n  = 1'b1;
            end
          end
`else
          if (cmd_load) begin
            dout_n = cmd_seed;
          end
`endif
          state_n = (cmd_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!hold) begin
          dout_n = dir_q ? shift_rev(dout_q) : shift_fwd(dout_q);
          rem_n  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dout_q <= '0;
      rem_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      state  <= state_n;
      dout_q <= dout_n;
      rem_q  <= rem_n;
      dir_q  <= dir_n;
    end
  end

`ifdef JSEQ_ILLEGAL_RECOVERY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_n;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dout      = dout_q;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_steps;
  logic       cmd_dir;
  logic       cmd_load;
  logic [3:0] cmd_seed;
  logic       hold;
  logic [3:0] dout;
  logic [7:0] phase;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_load  (cmd_load),
    .cmd_seed  (cmd_seed),
    .hold      (hold),
    .dout      (dout),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fwd8 [8];
  logic [3:0] rev3 [3];
  logic [3:0] fwd3 [3];
  logic       early;

  initial begin
    fwd8 = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    rev3 = '{4'b0001, 4'b0011, 4'b0111};
    fwd3 = '{4'b0011, 4'b0001, 4'b0000};

    rst = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
    cmd_load = 1'b0; cmd_seed = '0; hold = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_dout",  dout, 4'b0000);
    chk("rst_phase", phase, 8'h01);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_err",   err, 1'b0);
    rst = 1'b1;
    tick();

    // forward 8: a full lap back to 0000
    cmd_valid = 1'b1; cmd_steps = 8'd8; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("f8_busy",  busy, 1'b1);
    chk("f8_ready", cmd_ready, 1'b0);
    chk("f8_dout0", dout, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("f8_dout%0d", k + 1), dout, fwd8[k]);
      chk($sformatf("f8_done%0d", k + 1), done, (k == 7) ? 1'b1 : 1'b0);
      if (k == 1) chk("f8_phase_1100", phase, 8'b0000_0100);
    end
    tick();
    chk("f8_done_end",  done, 1'b0);
    chk("f8_ready_end", cmd_ready, 1'b1);
    chk("f8_dout_end",  dout, 4'b0000);

    // reverse 3, then forward 3 undoes it
    cmd_valid = 1'b1; cmd_steps = 8'd3; cmd_dir = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("r3_dout%0d", k + 1), dout, rev3[k]);
    end
    chk("r3_phase_0111", phase, 8'b0010_0000);
    chk("r3_done", done, 1'b1);
    tick();
    cmd_valid = 1'b1; cmd_steps = 8'd3; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("f3_dout%0d", k + 1), dout, fwd3[k]);
    end
    chk("f3_done", done, 1'b1);
    tick();

    // forward 4 with two hold cycles after the second shift
    cmd_valid = 1'b1; cmd_steps = 8'd4; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick(); chk("h_dout1", dout, 4'b1000);
    tick(); chk("h_dout2", dout, 4'b1100);
    hold = 1'b1;
    tick(); chk("h_hold1", dout, 4'b1100); chk("h_hold1_done", done, 1'b0);
    tick(); chk("h_hold2", dout, 4'b1100); chk("h_hold2_done", done, 1'b0);
    hold = 1'b0;
    tick(); chk("h_dout3", dout, 4'b1110); chk("h_done3", done, 1'b0);
    tick(); chk("h_dout4", dout, 4'b1111); chk("h_done4", done, 1'b1);
    tick(); chk("h_idle", cmd_ready, 1'b1);

    // steps=0 with seed load; valid held through DONE
    cmd_valid = 1'b1; cmd_steps = 8'd0; cmd_load = 1'b1; cmd_seed = 4'b0011;
    tick();
    chk("z_dout", dout, 4'b0011);
    chk("z_done", done, 1'b1);
    chk("z_ready", cmd_ready, 1'b0);
    cmd_steps = 8'd2; cmd_load = 1'b0; cmd_dir = 1'b0;
    tick();
    chk("z_notacc_busy", busy, 1'b0);
    chk("z_notacc_done", done, 1'b0);
    chk("z_notacc_dout", dout, 4'b0011);
    tick();
    cmd_valid = 1'b0;
    chk("z_acc_busy", busy, 1'b1);
    tick(); chk("z_s1", dout, 4'b0001);
    tick(); chk("z_s2", dout, 4'b0000); chk("z_s2_done", done, 1'b1);
    tick();

    // illegal seed 0101, steps=1
    cmd_valid = 1'b1; cmd_steps = 8'd1; cmd_load = 1'b1; cmd_seed = 4'b0101;
    tick();
    cmd_valid = 1'b0; cmd_load = 1'b0;
`ifdef JSEQ_ILLEGAL_RECOVERY_EN
    chk("il_load", dout, 4'b0000);
    chk("il_err0", err, 1'b1);
    tick();
    chk("il_shift", dout, 4'b1000);
    chk("il_phase", phase, 8'h02);
    chk("il_err1", err, 1'b1);
`else
    chk("il_load", dout, 4'b0101);
    chk("il_phase0", phase, 8'h00);
    chk("il_err0", err, 1'b0);
    tick();
    chk("il_shift", dout, 4'b0010);
    chk("il_phase", phase, 8'h00);
    chk("il_err1", err, 1'b0);
`endif
    chk("il_done", done, 1'b1);
    tick();
`ifdef JSEQ_ILLEGAL_RECOVERY_EN
    chk("il_err_idle", err, 1'b1);
`else
    chk("il_err_idle", err, 1'b0);
`endif
    cmd_valid = 1'b1; cmd_steps = 8'd0; cmd_load = 1'b1; cmd_seed = 4'b0000;
    tick();
    cmd_valid = 1'b0; cmd_load = 1'b0;
    chk("il_err_clr", err, 1'b0);
    chk("il_reload", dout, 4'b0000);
    tick();

    // reset mid-RUN of steps=5 after two shifts
    cmd_valid = 1'b1; cmd_steps = 8'd5; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("mr_pre", dout, 4'b1100);
    #2 rst = 1'b0;
    #1;
    chk("mr_dout",  dout, 4'b0000);
    chk("mr_busy",  busy, 1'b0);
    chk("mr_ready", cmd_ready, 1'b1);
    chk("mr_phase", phase, 8'h01);
    tick();
    chk("mr_done_inrst", done, 1'b0);
    rst = 1'b1;
    tick();
    chk("mr_done_after", done, 1'b0);
    chk("mr_dout_after", dout, 4'b0000);

    // maximum step count 255: no wrap, 255 mod 8 = 7 -> 0001
    cmd_valid = 1'b1; cmd_steps = 8'd255; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    early = 1'b0;
    repeat (254) begin
      tick();
      early = early | done;
    end
    chk("max_no_early_done", early, 1'b0);
    tick();
    chk("max_done", done, 1'b1);
    chk("max_dout", dout, 4'b0001);
    tick();
    chk("max_idle", cmd_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
